// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer and its settle timer.
package alu_seq_pkg;

  localparam int CTRL_W   = 4;
  localparam int SETTLE_W = 4;

  localparam logic [CTRL_W-1:0] CTRL_LAST = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    PRESENT
  } seq_state_e;

endpackage

// File: rtl/alu_seq_settle_timer.sv
// Loadable down-counter; zero_next flags the enabled cycle whose edge brings it to zero.
module alu_seq_settle_timer
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  input  logic                en,
  output logic                zero_next
);

  logic [SETTLE_W-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign zero_next = en && (count == SETTLE_W'(1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational ALU from registered operands and returns each settled result,
// optionally sweeping the opcode up to 4'hF.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sweep,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CTRL_W-1:0] rsp_ctrl,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_last,
  output logic              busy
);

  seq_state_e state;
  logic       sweep_r;
  logic       accept;
  logic       handshake;
  logic       settle_done;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == PRESENT);

  assign accept    = cmd_ready && cmd_valid;
  assign handshake = rsp_valid && rsp_ready;

  // Reload on every accept and on every handshake that continues a sweep.
  alu_seq_settle_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (accept || (handshake && !rsp_last)),
    .value     (SETTLE_W'(SETTLE_CYC)),
    .en        (state == DRIVE),
    .zero_next (settle_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sweep_r    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_ctrl   <= '0;
      rsp_result <= '0;
      rsp_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_ctrl <= cmd_ctrl;
            sweep_r  <= cmd_sweep;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_done) begin
            rsp_result <= alu_result;
            rsp_ctrl   <= alu_ctrl;
            rsp_last   <= !sweep_r || (alu_ctrl == CTRL_LAST);
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              // rsp_last is set on 4'hF, so this increment never wraps.
              alu_ctrl <= alu_ctrl + CTRL_W'(1);
              state    <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer with a stub adder ALU.
module tb_alu_cmd_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  // Instance with SETTLE_CYC = 1
  logic       cmd_valid, cmd_ready, cmd_sweep;
  logic [3:0] cmd_ctrl;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl;
  logic       rsp_valid, rsp_ready, rsp_last, busy;
  logic [3:0] rsp_ctrl;
  logic [7:0] rsp_result;

  // Instance with SETTLE_CYC = 4
  logic       cmd_valid4, cmd_ready4, cmd_sweep4;
  logic [3:0] cmd_ctrl4;
  logic [7:0] cmd_a4, cmd_b4;
  logic [7:0] alu_a4, alu_b4, alu_result4;
  logic [3:0] alu_ctrl4;
  logic       rsp_valid4, rsp_ready4, rsp_last4, busy4;
  logic [3:0] rsp_ctrl4;
  logic [7:0] rsp_result4;

  assign alu_result  = alu_a + alu_b + {4'h0, alu_ctrl};
  assign alu_result4 = alu_a4 + alu_b4 + {4'h0, alu_ctrl4};

  alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sweep(cmd_sweep),
    .cmd_ctrl(cmd_ctrl), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ctrl(rsp_ctrl),
    .rsp_result(rsp_result), .rsp_last(rsp_last), .busy(busy)
  );

  alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_sweep(cmd_sweep4),
    .cmd_ctrl(cmd_ctrl4), .cmd_a(cmd_a4), .cmd_b(cmd_b4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_ctrl(alu_ctrl4), .alu_result(alu_result4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_ctrl(rsp_ctrl4),
    .rsp_result(rsp_result4), .rsp_last(rsp_last4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the stub ALU result for one opcode, and the opcode list a command produces.
  function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    int sum;
    sum = int'(a) + int'(b) + int'(op);
    return 8'(sum % 256);
  endfunction

  task automatic check_reset_state(input string p);
    check({p, "_cmd_ready"},  32'(cmd_ready),  32'd1);
    check({p, "_busy"},       32'(busy),       32'd0);
    check({p, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({p, "_rsp_last"},   32'(rsp_last),   32'd0);
    check({p, "_rsp_ctrl"},   32'(rsp_ctrl),   32'd0);
    check({p, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({p, "_alu_a"},      32'(alu_a),      32'd0);
    check({p, "_alu_b"},      32'(alu_b),      32'd0);
    check({p, "_alu_ctrl"},   32'(alu_ctrl),   32'd0);
  endtask

  // One command on the SETTLE_CYC = 1 instance. stall: cycles of rsp_ready low per response.
  // abort_after > 0: assert rst after that many handshakes. span > 0: required E0..last-handshake edges.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                         input logic sw, input int stall, input int abort_after, input int span);
    int         e0, hs, n;
    logic [3:0] op;
    logic [3:0] cval;
    for (int w = 0; w < 64 && !cmd_ready; w++) @(negedge clk);
    check("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_ctrl = c; cmd_sweep = sw;
    @(negedge clk);
    e0 = cyc;
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_ctrl = 4'($urandom); cmd_sweep = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("alu_ctrl_loaded", 32'(alu_ctrl), 32'(c));
    cval = c;
    n = sw ? (16 - int'(cval)) : 1;
    hs = e0;
    rsp_ready = (stall == 0);
    for (int k = 0; k < n; k++) begin
      op = 4'(int'(cval) + k);
      for (int w = 0; w < 64 && !rsp_valid; w++) @(negedge clk);
      check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      if (k == 0) check("first_latency", 32'(cyc - e0), 32'd1);
      check("rsp_ctrl", 32'(rsp_ctrl), 32'(op));
      check("rsp_result", 32'(rsp_result), 32'(ref_result(a, b, op)));
      check("rsp_last", 32'(rsp_last), 32'(!sw || op == 4'hF));
      check("alu_a_const", 32'(alu_a), 32'(a));
      check("alu_b_const", 32'(alu_b), 32'(b));
      check("alu_ctrl_op", 32'(alu_ctrl), 32'(op));
      for (int s = 0; s < stall; s++) begin
        rsp_ready = 1'b0;
        @(negedge clk);
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_rsp_ctrl", 32'(rsp_ctrl), 32'(op));
        check("stall_rsp_result", 32'(rsp_result), 32'(ref_result(a, b, op)));
        check("stall_alu_ctrl", 32'(alu_ctrl), 32'(op));
        check("stall_alu_a", 32'(alu_a), 32'(a));
      end
      rsp_ready = 1'b1;
      hs = cyc + 1;
      @(negedge clk);
      check("valid_drop", 32'(rsp_valid), 32'd0);
      if (stall > 0) rsp_ready = 1'b0;
      if (k + 1 == abort_after) begin
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("postrst");
        return;
      end
    end
    if (span > 0) check("last_hs_edge", 32'(hs - e0), 32'(span));
    check("busy_done", 32'(busy), 32'd0);
    check("cmd_ready_done", 32'(cmd_ready), 32'd1);
    check("alu_a_hold", 32'(alu_a), 32'(a));
    rsp_ready = 1'b0;
  endtask

  initial begin
    int e0;
    cyc = 0; n_checks = 0; n_errors = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_sweep = 1'b0; cmd_ctrl = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    cmd_valid4 = 1'b0; cmd_sweep4 = 1'b0; cmd_ctrl4 = '0; cmd_a4 = '0; cmd_b4 = '0; rsp_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check("reset4_cmd_ready", 32'(cmd_ready4), 32'd1);
    check("reset4_busy", 32'(busy4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(8'h00, 8'h01, 4'h3, 1'b0, 0, 0, 2);    // single op
    run_cmd(8'h00, 8'h01, 4'h0, 1'b1, 0, 0, 32);   // full sweep
    run_cmd(8'h00, 8'h01, 4'hD, 1'b1, 5, 0, 0);    // backpressure
    run_cmd(8'hFF, 8'hFF, 4'hF, 1'b1, 0, 0, 0);    // sweep from last opcode, result wraps
    check("alu_ctrl_no_wrap", 32'(alu_ctrl), 32'hF);
    run_cmd(8'h12, 8'h34, 4'h0, 1'b1, 0, 5, 0);    // reset mid-sweep
    run_cmd(8'h05, 8'h06, 4'h7, 1'b0, 0, 0, 2);    // recovery

    for (int i = 0; i < 8; i++) begin
      logic       sw;
      logic [3:0] c;
      sw = 1'($urandom_range(0, 1));
      c  = sw ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 15));
      run_cmd(8'($urandom), 8'($urandom), c, sw, int'($urandom_range(0, 3)), 0, 0);
    end

    // SETTLE_CYC = 4 instance; cmd_valid stays high through busy and across the final handshake.
    @(negedge clk);
    cmd_valid4 = 1'b1; cmd_a4 = 8'h10; cmd_b4 = 8'h20; cmd_ctrl4 = 4'h2; cmd_sweep4 = 1'b0;
    @(negedge clk);
    e0 = cyc;
    cmd_a4 = 8'h77; cmd_b4 = 8'h01; cmd_ctrl4 = 4'h5;
    check("s4_busy", 32'(busy4), 32'd1);
    for (int w = 0; w < 64 && !rsp_valid4; w++) @(negedge clk);
    check("s4_latency", 32'(cyc - e0), 32'd4);
    check("s4_alu_a_held", 32'(alu_a4), 32'h10);
    check("s4_alu_ctrl_held", 32'(alu_ctrl4), 32'h2);
    check("s4_rsp_result", 32'(rsp_result4), 32'(ref_result(8'h10, 8'h20, 4'h2)));
    check("s4_rsp_ctrl", 32'(rsp_ctrl4), 32'h2);
    check("s4_rsp_last", 32'(rsp_last4), 32'd1);
    rsp_ready4 = 1'b1;
    @(negedge clk);
    rsp_ready4 = 1'b0;
    check("s4_no_b2b_busy", 32'(busy4), 32'd0);
    check("s4_no_b2b_ready", 32'(cmd_ready4), 32'd1);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    check("s4_second_accept", 32'(busy4), 32'd1);
    check("s4_second_alu_a", 32'(alu_a4), 32'h77);
    for (int w = 0; w < 64 && !rsp_valid4; w++) @(negedge clk);
    check("s4_second_result", 32'(rsp_result4), 32'(ref_result(8'h77, 8'h01, 4'h5)));
    check("s4_second_ctrl", 32'(rsp_ctrl4), 32'h5);
    rsp_ready4 = 1'b1;
    @(negedge clk);
    rsp_ready4 = 1'b0;
    check("s4_done", 32'(busy4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
